// File: rtl/fpu_norm_pipe.sv
// Two-stage FPU normalizer: leading-zero count in S1, shift/exponent adjust into S2.
// Define FPU_NORM_SUBNORM_EN for gradual subnormals on underflow; otherwise underflow flushes to zero.
module fpu_norm_pipe #(
   parameter int MANT_W = 28,
   parameter int EXP_W  = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [MANT_W-1:0] mant_i,
   input  logic [EXP_W-1:0]  exp_i,
   input  logic              sign_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [MANT_W-1:0] mant_o,
   output logic [EXP_W-1:0]  exp_o,
   output logic              sign_o,
   output logic              zero_o,
   output logic              denorm_o
);

   localparam int LZ_W = $clog2(MANT_W);

   logic              v1;
   logic              v2;
   logic              advance1;
   logic              advance2;

   logic [MANT_W-1:0] mant1;
   logic [EXP_W-1:0]  exp1;
   logic              sign1;
   logic [LZ_W-1:0]   lz1;
   logic              nz1;

   logic [LZ_W-1:0]   first_one;
   logic              nz_c;
   logic [LZ_W-1:0]   lz_c;

   logic signed [EXP_W:0] exp_ext;
   logic signed [EXP_W:0] lz_ext;
   logic signed [EXP_W:0] exp_adj;
`ifdef FPU_NORM_SUBNORM_EN
   logic signed [EXP_W:0] exp_m1;
   logic [LZ_W-1:0]       shift_sub;
`endif

   logic [MANT_W-1:0] mant_n;
   logic [EXP_W-1:0]  exp_n;
   logic              zero_n;
   logic              denorm_n;

   assign advance2    = !v2 || out_ready_i;
   assign advance1    = !v1 || advance2;
   assign in_ready_o  = advance1;
   assign out_valid_o = v2;

   // Find-first-one: the highest set bit wins because later iterations overwrite.
   always_comb begin
      first_one = '0;
      nz_c      = 1'b0;
      for (int i = 0; i < MANT_W; i++) begin
         if (mant_i[i]) begin
            first_one = i[LZ_W-1:0];
            nz_c      = 1'b1;
         end
      end
      lz_c = LZ_W'(MANT_W - 1) - first_one;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1 <= 1'b0;
      end else if (advance1) begin
         v1 <= in_valid_i;
         if (in_valid_i) begin
            mant1 <= mant_i;
            exp1  <= exp_i;
            sign1 <= sign_i;
            lz1   <= lz_c;
            nz1   <= nz_c;
         end
      end
   end

   // One extra exponent bit keeps exp - lz from wrapping; the result never exceeds exp.
   always_comb begin
      exp_ext  = {exp1[EXP_W-1], exp1};
      lz_ext   = {{(EXP_W + 1 - LZ_W){1'b0}}, lz1};
      exp_adj  = exp_ext - lz_ext;
      mant_n   = '0;
      exp_n    = '0;
      zero_n   = 1'b0;
      denorm_n = 1'b0;
`ifdef FPU_NORM_SUBNORM_EN
      exp_m1    = exp_ext - {{EXP_W{1'b0}}, 1'b1};
      shift_sub = '0;
`endif
      if (!nz1) begin
         zero_n = 1'b1;
      end else if (!exp_adj[EXP_W] && (exp_adj != '0)) begin
         mant_n = mant1 << lz1;
         exp_n  = exp_adj[EXP_W-1:0];
      end else begin
`ifdef FPU_NORM_SUBNORM_EN
         if (exp_m1[EXP_W]) begin
            shift_sub = '0;
         end else if (exp_m1 > lz_ext) begin
            shift_sub = lz1;
         end else begin
            shift_sub = exp_m1[LZ_W-1:0];
         end
         mant_n   = mant1 << shift_sub;
         denorm_n = 1'b1;
`else
         zero_n = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v2       <= 1'b0;
         mant_o   <= '0;
         exp_o    <= '0;
         sign_o   <= 1'b0;
         zero_o   <= 1'b0;
         denorm_o <= 1'b0;
      end else if (advance2) begin
         v2 <= v1;
         if (v1) begin
            mant_o   <= mant_n;
            exp_o    <= exp_n;
            sign_o   <= sign1;
            zero_o   <= zero_n;
            denorm_o <= denorm_n;
         end
      end
   end

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Self-checking bench for fpu_norm_pipe: directed test-plan cases, backpressure, reset mid-stall,
// then randomized traffic against an arithmetic reference model with an in-order scoreboard.
module tb_fpu_norm_pipe;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [27:0] mant_i;
   logic [9:0]  exp_i;
   logic        sign_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [27:0] mant_o;
   logic [9:0]  exp_o;
   logic        sign_o;
   logic        zero_o;
   logic        denorm_o;

   fpu_norm_pipe #(.MANT_W(28), .EXP_W(10)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .mant_i      (mant_i),
      .exp_i       (exp_i),
      .sign_i      (sign_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .mant_o      (mant_o),
      .exp_o       (exp_o),
      .sign_o      (sign_o),
      .zero_o      (zero_o),
      .denorm_o    (denorm_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [27:0] mant;
      logic [9:0]  expo;
      logic        sign;
      logic        zero;
      logic        denorm;
   } res_t;

   typedef struct packed {
      logic [27:0] m;
      logic [9:0]  e;
      logic        s;
      logic [27:0] xm;
      logic [9:0]  xe;
      logic        xz;
      logic        xd;
   } case_t;

   res_t  exp_q[$];
   case_t cases[7];
   int    errors    = 0;
   int    checks    = 0;
   int    out_count = 0;
   logic  in_acc;

   // Reference: normalize by repeated doubling, then apply the underflow rule on the integer exponent.
   function automatic res_t model(input logic [27:0] m, input logic [9:0] e_bits, input logic s);
      res_t        r;
      int          e;
      int          lz;
      int          sh;
      logic [27:0] mm;
      r      = '0;
      r.sign = s;
      e      = $signed(e_bits);
      if (m == 28'd0) begin
         r.zero = 1'b1;
      end else begin
         lz = 0;
         mm = m;
         while (!mm[27]) begin
            mm = mm << 1;
            lz = lz + 1;
         end
         if (e - lz >= 1) begin
            r.mant = mm;
            r.expo = 10'(e - lz);
         end else begin
`ifdef FPU_NORM_SUBNORM_EN
            sh = (e - 1 < 0) ? 0 : e - 1;
            if (sh > lz) sh = lz;
            r.mant   = m << sh;
            r.denorm = 1'b1;
`else
            sh     = 0;
            r.zero = 1'b1;
`endif
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [27:0] m, input logic [9:0] e,
                                input logic s, input logic ordy);
      in_valid_i  = v;
      mant_i      = m;
      exp_i       = e;
      sign_i      = s;
      out_ready_i = ordy;
   endtask

   // Handshake bookkeeping at the falling edge, then advance past the next rising edge.
   task automatic stepCycle();
      res_t r;
      @(negedge clk_i);
      in_acc = 1'b0;
      if (!rst_i) begin
         if (out_valid_o && out_ready_i) begin
            out_count++;
            checkOutput("sb_item_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               r = exp_q.pop_front();
               checkOutput("sb_mant",   64'(mant_o),   64'(r.mant));
               checkOutput("sb_exp",    64'(exp_o),    64'(r.expo));
               checkOutput("sb_sign",   64'(sign_o),   64'(r.sign));
               checkOutput("sb_zero",   64'(zero_o),   64'(r.zero));
               checkOutput("sb_denorm", 64'(denorm_o), 64'(r.denorm));
            end
         end
         if (in_valid_i && in_ready_o) begin
            in_acc = 1'b1;
            exp_q.push_back(model(mant_i, exp_i, sign_i));
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL timeout simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int          k;
      int          start_cnt;
      logic [27:0] rm;
      logic [9:0]  re;

      cases[0] = '{28'h0000100, 10'd100, 1'b0, 28'h8000000, 10'd81, 1'b0, 1'b0};
      cases[1] = '{28'h8000001, 10'd3,   1'b0, 28'h8000001, 10'd3,  1'b0, 1'b0};
      cases[3] = '{28'h0000000, 10'd50,  1'b1, 28'h0000000, 10'd0,  1'b1, 1'b0};
      cases[4] = '{28'h0000100, 10'd20,  1'b0, 28'h8000000, 10'd1,  1'b0, 1'b0};
`ifdef FPU_NORM_SUBNORM_EN
      cases[2] = '{28'h0000100, 10'd5,   1'b0, 28'h0001000, 10'd0,  1'b0, 1'b1};
      cases[5] = '{28'h0000100, 10'd19,  1'b0, 28'h4000000, 10'd0,  1'b0, 1'b1};
      cases[6] = '{28'h0000100, 10'h3FD, 1'b1, 28'h0000100, 10'd0,  1'b0, 1'b1};
`else
      cases[2] = '{28'h0000100, 10'd5,   1'b0, 28'h0000000, 10'd0,  1'b1, 1'b0};
      cases[5] = '{28'h0000100, 10'd19,  1'b0, 28'h0000000, 10'd0,  1'b1, 1'b0};
      cases[6] = '{28'h0000100, 10'h3FD, 1'b1, 28'h0000000, 10'd0,  1'b1, 1'b0};
`endif

      rst_i = 1'b1;
      applyStimulus(1'b0, 28'd0, 10'd0, 1'b0, 1'b0);
      stepCycle();
      stepCycle();
      rst_i = 1'b0;
      exp_q.delete();
      $display("[TB] reset released");
      checkOutput("rst_out_valid", 64'(out_valid_o), 64'(0));
      checkOutput("rst_in_ready",  64'(in_ready_o),  64'(1));
      checkOutput("rst_data", 64'({mant_o, exp_o, sign_o, zero_o, denorm_o}), 64'(0));

      // Directed test-plan cases, one at a time, with the two-cycle latency checked explicitly.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, cases[i].m, cases[i].e, cases[i].s, 1'b1);
         stepCycle();
         applyStimulus(1'b0, 28'd0, 10'd0, 1'b0, 1'b1);
         checkOutput("lat_not_yet", 64'(out_valid_o), 64'(0));
         stepCycle();
         checkOutput("lat_valid",   64'(out_valid_o), 64'(1));
         checkOutput("dir_mant",    64'(mant_o),      64'(cases[i].xm));
         checkOutput("dir_exp",     64'(exp_o),       64'(cases[i].xe));
         checkOutput("dir_sign",    64'(sign_o),      64'(cases[i].s));
         checkOutput("dir_zero",    64'(zero_o),      64'(cases[i].xz));
         checkOutput("dir_denorm",  64'(denorm_o),    64'(cases[i].xd));
         stepCycle();
      end

      // Backpressure: four back-to-back items, out_ready low for cycles 0-4.
      $display("[TB] backpressure sequence");
      k = 0;
      start_cnt = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         if (k < 4) applyStimulus(1'b1, 28'h8000000, 10'(10 + k), 1'b0, cyc >= 5);
         else       applyStimulus(1'b0, 28'd0, 10'd0, 1'b0, cyc >= 5);
         if (cyc == 2) begin
            checkOutput("bp_accepts",  64'(k),          64'(2));
            checkOutput("bp_in_ready", 64'(in_ready_o), 64'(0));
         end
         if (cyc == 2 || cyc == 4) begin
            checkOutput("bp_hold_valid", 64'(out_valid_o), 64'(1));
            checkOutput("bp_hold_exp",   64'(exp_o),       64'(10));
            checkOutput("bp_hold_mant",  64'(mant_o),      64'(28'h8000000));
         end
         if (cyc == 5) start_cnt = out_count;
         if (cyc == 9) checkOutput("bp_no_gaps", 64'(out_count - start_cnt), 64'(4));
         stepCycle();
         if (in_acc) k++;
      end
      checkOutput("bp_drained", 64'(exp_q.size()), 64'(0));

      // Reset while stalled with two items in flight.
      $display("[TB] reset mid-stall");
      applyStimulus(1'b1, 28'h0ABCDEF, 10'd40, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 28'h1234567, 10'd41, 1'b1, 1'b0);
      stepCycle();
      checkOutput("ms_full", 64'(in_ready_o), 64'(0));
      rst_i = 1'b1;
      applyStimulus(1'b0, 28'd0, 10'd0, 1'b0, 1'b0);
      stepCycle();
      rst_i = 1'b0;
      exp_q.delete();
      checkOutput("ms_out_valid", 64'(out_valid_o), 64'(0));
      checkOutput("ms_in_ready",  64'(in_ready_o),  64'(1));
      checkOutput("ms_data", 64'({mant_o, exp_o, sign_o, zero_o, denorm_o}), 64'(0));
      start_cnt = out_count;
      applyStimulus(1'b0, 28'd0, 10'd0, 1'b0, 1'b1);
      for (int cyc = 0; cyc < 5; cyc++) stepCycle();
      checkOutput("ms_no_stale", 64'(out_count - start_cnt), 64'(0));

      // Random traffic with random backpressure; inputs held until accepted.
      $display("[TB] random traffic");
      in_acc = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!in_valid_i || in_acc) begin
            rm = 28'($urandom) >> $urandom_range(0, 28);
            if ($urandom_range(0, 3) == 0) re = 10'($urandom);
            else                           re = 10'($urandom_range(0, 70) - 10);
            applyStimulus($urandom_range(0, 9) < 7, rm, re, 1'($urandom), $urandom_range(0, 3) != 0);
         end else begin
            out_ready_i = $urandom_range(0, 3) != 0;
         end
         stepCycle();
      end

      applyStimulus(1'b0, 28'd0, 10'd0, 1'b0, 1'b1);
      for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) stepCycle();
      checkOutput("final_drain", 64'(exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
